// File: rtl/nfc_way_command_scheduler.sv
// Per-way command scheduler: one FIFO per NAND way, round-robin issue among ready ways,
// single outstanding command towards the controller over a valid/ready handshake.
module nfc_way_command_scheduler #(
  parameter int NumberOfWays    = 2,
  parameter int QueueDepth      = 4,
  parameter int BusyGuardCycles = 4
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic                    iCmdValid,
  output logic                    oCmdReady,
  input  logic [5:0]              iOpcode,
  input  logic [4:0]              iTargetID,
  input  logic [31:0]             iAddress,
  input  logic [15:0]             iLength,
  output logic                    oCmdReject,
  output logic [5:0]              oOpcode,
  output logic [4:0]              oTargetID,
  output logic [4:0]              oSourceID,
  output logic [31:0]             oAddress,
  output logic [15:0]             oLength,
  output logic                    oCMDValid,
  input  logic                    iCMDReady,
  input  logic [NumberOfWays-1:0] iReadyBusy,
  output logic [NumberOfWays-1:0] oQueueEmpty,
  output logic [NumberOfWays-1:0] oQueueFull,
  output logic                    oIdle
);

  localparam int AW = $clog2(QueueDepth);
  localparam int WW = (NumberOfWays > 1) ? $clog2(NumberOfWays) : 1;
  localparam int GW = $clog2(BusyGuardCycles + 1);
  localparam int EW = 6 + 32 + 16;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [EW-1:0] mem_q   [NumberOfWays][QueueDepth];
  logic [AW-1:0] wptr_q  [NumberOfWays];
  logic [AW-1:0] rptr_q  [NumberOfWays];
  logic [AW:0]   cnt_q   [NumberOfWays];
  logic [GW-1:0] guard_q [NumberOfWays];

  logic [0:0]    state_q, state_d;
  logic          valid_q, valid_d;
  logic [WW-1:0] sel_q, sel_d;
  logic [WW-1:0] rr_q, rr_d;
  logic [5:0]    op_q, op_d;
  logic [4:0]    tgt_q, tgt_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   len_q, len_d;
  logic          reject_q;

  logic                    tgt_legal;
  logic [NumberOfWays-1:0] push_sel, push, pop, empty, full, elig;
  logic                    found;
  logic [WW-1:0]           grant;
  logic [EW-1:0]           head;
  int unsigned             idx;

  always_comb begin
    tgt_legal = int'(iTargetID) < NumberOfWays;
    for (int unsigned w = 0; w < NumberOfWays; w++) begin
      push_sel[w] = (iTargetID == 5'(w));
      empty[w]    = (cnt_q[w] == '0);
      full[w]     = (cnt_q[w] == (AW+1)'(QueueDepth));
      elig[w]     = !empty[w] && iReadyBusy[w] && (guard_q[w] == '0);
    end
    // Illegal targets are always accepted so they can be dropped and flagged.
    oCmdReady = !tgt_legal || ~|(push_sel & full);
    push      = push_sel & {NumberOfWays{iCmdValid && oCmdReady}};
    for (int unsigned w = 0; w < NumberOfWays; w++) begin
      pop[w] = (state_q == S_ISSUE) && iCMDReady && (sel_q == WW'(w));
    end
  end

  // Round-robin search starting at the pointer, wrapping over the way count.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NumberOfWays; k++) begin
      idx = (32'(rr_q) + k) % NumberOfWays;
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = WW'(idx);
      end
    end
  end

  assign head = mem_q[grant][rptr_q[grant]];

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    op_d    = op_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d                = S_ISSUE;
          valid_d                = 1'b1;
          sel_d                  = grant;
          tgt_d                  = 5'(grant);
          {op_d, addr_d, len_d}  = head;
        end
      end
      S_ISSUE: begin
        if (iCMDReady) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          rr_d    = (sel_q == WW'(NumberOfWays - 1)) ? '0 : sel_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      sel_q    <= '0;
      rr_q     <= '0;
      op_q     <= '0;
      tgt_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      reject_q <= 1'b0;
      for (int unsigned w = 0; w < NumberOfWays; w++) begin
        wptr_q[w]  <= '0;
        rptr_q[w]  <= '0;
        cnt_q[w]   <= '0;
        guard_q[w] <= '0;
      end
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
      op_q     <= op_d;
      tgt_q    <= tgt_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      reject_q <= iCmdValid && oCmdReady && !tgt_legal;
      for (int unsigned w = 0; w < NumberOfWays; w++) begin
        if (push[w]) wptr_q[w] <= wptr_q[w] + 1'b1;
        if (pop[w])  rptr_q[w] <= rptr_q[w] + 1'b1;
        cnt_q[w] <= cnt_q[w] + (AW+1)'(push[w]) - (AW+1)'(pop[w]);
        if (pop[w])                guard_q[w] <= GW'(BusyGuardCycles);
        else if (guard_q[w] != '0) guard_q[w] <= guard_q[w] - 1'b1;
      end
    end
  end

  always_ff @(posedge iSystemClock) begin
    for (int unsigned w = 0; w < NumberOfWays; w++) begin
      if (push[w]) mem_q[w][wptr_q[w]] <= {iOpcode, iAddress, iLength};
    end
  end

  assign oCmdReject  = reject_q;
  assign oOpcode     = op_q;
  assign oTargetID   = tgt_q;
  assign oSourceID   = '0;
  assign oAddress    = addr_q;
  assign oLength     = len_q;
  assign oCMDValid   = valid_q;
  assign oQueueEmpty = empty;
  assign oQueueFull  = full;
  assign oIdle       = (&empty) && (state_q == S_IDLE);

endmodule

// File: tb/tb_nfc_way_command_scheduler.sv
// Bench for nfc_way_command_scheduler: per-way expected queues filled on acceptance,
// a negedge monitor predicts arbitration from way readiness and issue history.
module tb_nfc_way_command_scheduler;
  localparam int N  = 2;
  localparam int QD = 4;
  localparam int BG = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iCmdValid = 1'b0;
  logic          oCmdReady;
  logic [5:0]    iOpcode = '0;
  logic [4:0]    iTargetID = '0;
  logic [31:0]   iAddress = '0;
  logic [15:0]   iLength = '0;
  logic          oCmdReject;
  logic [5:0]    oOpcode;
  logic [4:0]    oTargetID;
  logic [4:0]    oSourceID;
  logic [31:0]   oAddress;
  logic [15:0]   oLength;
  logic          oCMDValid;
  logic          iCMDReady = 1'b0;
  logic [N-1:0]  iReadyBusy = '0;
  logic [N-1:0]  oQueueEmpty;
  logic [N-1:0]  oQueueFull;
  logic          oIdle;

  nfc_way_command_scheduler #(
    .NumberOfWays(N), .QueueDepth(QD), .BusyGuardCycles(BG)
  ) dut (
    .iSystemClock(clk), .iReset(rst_n), .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
    .iOpcode(iOpcode), .iTargetID(iTargetID), .iAddress(iAddress), .iLength(iLength),
    .oCmdReject(oCmdReject), .oOpcode(oOpcode), .oTargetID(oTargetID), .oSourceID(oSourceID),
    .oAddress(oAddress), .oLength(oLength), .oCMDValid(oCMDValid), .iCMDReady(iCMDReady),
    .iReadyBusy(iReadyBusy), .oQueueEmpty(oQueueEmpty), .oQueueFull(oQueueFull), .oIdle(oIdle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [15:0] len;
  } cmd_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  cmd_t mq [N][$];
  int   last_t [N];
  int   rr_m;
  bit   pred_valid, pred_rej;
  int   exp_way;
  int   issued_w[$];
  int   issued_t[$];

  bit   legal, rdy_exp, acc, have, all_empty, found;
  int   t, w, e_edge;
  cmd_t c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / reference model: the model state describes the cycle in progress.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mq[i].delete();
        last_t[i] = -1000;
      end
      rr_m = 0; pred_valid = 0; pred_rej = 0; exp_way = 0;
      chk("rst_valid", oCMDValid, 0);
      chk("rst_reject", oCmdReject, 0);
      chk("rst_empty", oQueueEmpty, {N{1'b1}});
      chk("rst_full", oQueueFull, 0);
      chk("rst_idle", oIdle, 1);
      chk("rst_fields", {oOpcode, oTargetID, oAddress, oLength}, 0);
    end else begin
      chk("valid", oCMDValid, pred_valid);
      chk("reject", oCmdReject, pred_rej);
      if (oCMDValid) begin
        chk("target", oTargetID, exp_way);
        have = (exp_way < N) && (mq[exp_way].size() > 0);
        chk("head_avail", have, 1);
        if (have) begin
          c = mq[exp_way][0];
          chk("opcode", oOpcode, c.op);
          chk("address", oAddress, c.addr);
          chk("length", oLength, c.len);
        end
        chk("source", oSourceID, 0);
      end
      all_empty = 1;
      for (int i = 0; i < N; i++) begin
        chk("q_empty", oQueueEmpty[i], mq[i].size() == 0);
        chk("q_full", oQueueFull[i], mq[i].size() == QD);
        if (mq[i].size() != 0) all_empty = 0;
      end
      chk("idle", oIdle, all_empty && !pred_valid);
      t = int'(iTargetID);
      legal = t < N;
      if (legal) rdy_exp = mq[t].size() < QD;
      else       rdy_exp = 1;
      chk("cmd_ready", oCmdReady, rdy_exp);

      acc      = iCmdValid && rdy_exp;
      pred_rej = acc && !legal;
      if (pred_valid && iCMDReady) begin
        if (mq[exp_way].size() > 0) void'(mq[exp_way].pop_front());
        last_t[exp_way] = cyc + 1;
        rr_m = (exp_way + 1) % N;
        issued_w.push_back(exp_way);
        issued_t.push_back(cyc + 1);
        pred_valid = 0;
      end else if (!pred_valid) begin
        // A way may be chosen once BG+1 edges have passed since its last transfer.
        e_edge = cyc + 1;
        found = 0;
        for (int k = 0; k < N; k++) begin
          w = (rr_m + k) % N;
          if (!found && mq[w].size() > 0 && iReadyBusy[w] && (e_edge - last_t[w] >= BG + 1)) begin
            found = 1;
            exp_way = w;
          end
        end
        pred_valid = found;
      end
      if (acc && legal) mq[t].push_back('{op: iOpcode, addr: iAddress, len: iLength});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_cmd(input logic [5:0] op, input logic [4:0] tgt,
                          input logic [31:0] a, input logic [15:0] l);
    bit ok;
    ok = 0;
    iCmdValid = 1; iOpcode = op; iTargetID = tgt; iAddress = a; iLength = l;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (oCmdReady) ok = 1;
      @(posedge clk);
      #1;
    end
    iCmdValid = 0;
    chk("push_accept", ok, 1);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      done = 1;
      for (int j = 0; j < N; j++) if (mq[j].size() != 0) done = 0;
      if (oCMDValid) done = 0;
      if (!done) step(1);
    end
    chk("drain", done, 1);
    step(BG + 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    rst_n = 1;
    #1;
    chk("t1_ready_tgt0", oCmdReady, 1);
    iReadyBusy = 2'b11;
    iCMDReady  = 1;
    step(1);

    // Basic latency and field transfer
    push_cmd(6'h01, 5'd0, 32'h1234, 16'h0800);
    chk("t2_not_yet", oCMDValid, 0);
    step(1);
    chk("t2_valid", oCMDValid, 1);
    chk("t2_fields", {oOpcode, oTargetID, oAddress, oLength}, {6'h01, 5'd0, 32'h1234, 16'h0800});
    chk("t2_source", oSourceID, 0);
    drain();

    // Round-robin order
    iCMDReady = 0;
    issued_w.delete(); issued_t.delete();
    push_cmd(6'h02, 5'd0, 32'hA0, 16'h1);
    push_cmd(6'h03, 5'd0, 32'hA1, 16'h2);
    push_cmd(6'h04, 5'd1, 32'hB0, 16'h3);
    push_cmd(6'h05, 5'd1, 32'hB1, 16'h4);
    iCMDReady = 1;
    drain();
    chk("t3_count", issued_w.size(), 4);
    if (issued_w.size() == 4) begin
      chk("t3_order0", issued_w[0], 0);
      chk("t3_order1", issued_w[1], 1);
      chk("t3_order2", issued_w[2], 0);
      chk("t3_order3", issued_w[3], 1);
    end

    // Busy way does not block a ready way; guard spacing on the same way
    iReadyBusy = 2'b10;
    issued_w.delete(); issued_t.delete();
    push_cmd(6'h06, 5'd0, 32'hC0, 16'h5);
    push_cmd(6'h07, 5'd1, 32'hD0, 16'h6);
    push_cmd(6'h08, 5'd1, 32'hD1, 16'h7);
    step(12);
    chk("t4_count", issued_w.size(), 2);
    if (issued_w.size() == 2) begin
      chk("t4_first", issued_w[0], 1);
      chk("t4_second", issued_w[1], 1);
      chk("t4_gap", (issued_t[1] - issued_t[0]) >= BG + 2, 1);
    end
    iReadyBusy = 2'b11;
    drain();
    chk("t4_w0_last", (issued_w.size() == 3) && (issued_w[2] == 0), 1);

    // Queue full, stall, held command
    iCMDReady = 0;
    for (int i = 0; i < 4; i++) push_cmd(6'(8 + i), 5'd0, 32'(32'hE0 + i), 16'(i));
    chk("t5_full", oQueueFull[0], 1);
    iCmdValid = 1; iOpcode = 6'h3F; iTargetID = 5'd0; iAddress = 32'hFFFF; iLength = 16'h9;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t5_stall", oCmdReady, 0);
      chk("t5_held", {oCMDValid, oOpcode, oAddress}, {1'b1, 6'h08, 32'hE0});
    end
    iCMDReady = 1;
    push_cmd(6'h3F, 5'd0, 32'hFFFF, 16'h9);
    drain();

    // Illegal target and reset during issue
    push_cmd(6'h11, 5'd5, 32'h55, 16'h55);
    chk("t6_reject", oCmdReject, 1);
    step(1);
    chk("t6_reject_pulse", oCmdReject, 0);
    chk("t6_nothing", {oCMDValid, oQueueEmpty}, {1'b0, 2'b11});
    iCMDReady = 0;
    push_cmd(6'h12, 5'd1, 32'h66, 16'h66);
    step(2);
    chk("t6_issue", oCMDValid, 1);
    rst_n = 0;
    #1;
    chk("t6_rst_valid", oCMDValid, 0);
    chk("t6_rst_empty", oQueueEmpty, 2'b11);
    step(2);
    rst_n = 1;
    iCMDReady = 1;
    step(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      iCmdValid  = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      iTargetID  = (r < 4) ? 5'd0 : (r < 8) ? 5'd1 : 5'($urandom_range(2, 31));
      iOpcode    = 6'($urandom);
      iAddress   = $urandom;
      iLength    = 16'($urandom);
      iReadyBusy = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      iCMDReady  = ($urandom_range(0, 4) < 3);
      step(1);
    end
    iCmdValid  = 0;
    iReadyBusy = 2'b11;
    iCMDReady  = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
